// File: rtl/decoder_onehot_reg_if.sv
// Handshake bundle for decoder_onehot_reg: request side (in_*) and result side (out_*, err).
// Defining DECODER_ONEHOT_PARITY_EN adds the in_par request bit.
interface decoder_onehot_reg_if #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned NUM_OUT = 4
);
    logic               in_valid;
    logic [ADDR_W-1:0]  in_addr;
`ifdef DECODER_ONEHOT_PARITY_EN
    logic               in_par;
`endif
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] out_onehot;
    logic [ADDR_W-1:0]  out_idx;
    logic               err;

`ifdef DECODER_ONEHOT_PARITY_EN
    modport master (
        output in_valid, in_addr, in_par, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx, err
    );
    modport slave (
        input  in_valid, in_addr, in_par, out_ready,
        output in_ready, out_valid, out_onehot, out_idx, err
    );
`else
    modport master (
        output in_valid, in_addr, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx, err
    );
    modport slave (
        input  in_valid, in_addr, out_ready,
        output in_ready, out_valid, out_onehot, out_idx, err
    );
`endif
endinterface

// File: rtl/decoder_onehot_reg.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides and a self-driven scan.
// Optional DECODER_ONEHOT_PARITY_EN: even parity over {in_par, in_addr} is required on captures.
module decoder_onehot_reg #(
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned HOLD    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    decoder_onehot_reg_if.slave         bus,
    input  logic                        scan_start,
    output logic                        busy
);
    typedef enum logic {StIdle, StScan} state_e;

    state_e             state_q;
    logic               out_valid_q;
    logic [NUM_OUT-1:0] onehot_q;
    logic [ADDR_W-1:0]  idx_q;
    logic               err_q;

    logic               can_load;
    logic               accept;
    logic               capture;
    logic               in_bad;
    logic               scan_last;
    logic [NUM_OUT-1:0] onehot_idle;

    function automatic logic [NUM_OUT-1:0] dec(input logic [ADDR_W-1:0] a);
        logic [NUM_OUT-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NUM_OUT); k++) begin
            v[k] = (32'(a) == 32'(k));
        end
        return v;
    endfunction

    assign accept   = out_valid_q && bus.out_ready;
    assign can_load = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == StIdle) && !scan_start && can_load;
    assign capture  = bus.in_valid && bus.in_ready;

`ifdef DECODER_ONEHOT_PARITY_EN
    assign in_bad = (32'(bus.in_addr) >= NUM_OUT) || (^{bus.in_par, bus.in_addr});
`else
    assign in_bad = (32'(bus.in_addr) >= NUM_OUT);
`endif

    assign scan_last   = (idx_q == ADDR_W'(NUM_OUT - 1));
    // Value the code register takes when an accept leaves it empty.
    assign onehot_idle = (HOLD != 0) ? onehot_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            onehot_q    <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (scan_start && can_load) begin
                        state_q     <= StScan;
                        out_valid_q <= 1'b1;
                        onehot_q    <= dec('0);
                        idx_q       <= '0;
                        err_q       <= 1'b0;
                    end else if (capture) begin
                        out_valid_q <= 1'b1;
                        idx_q       <= bus.in_addr;
                        err_q       <= in_bad;
                        onehot_q    <= in_bad ? '0 : dec(bus.in_addr);
                    end else if (accept) begin
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        onehot_q    <= onehot_idle;
                    end
                end
                StScan: begin
                    if (accept) begin
                        if (scan_last) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                            err_q       <= 1'b0;
                            onehot_q    <= onehot_idle;
                        end else begin
                            idx_q    <= idx_q + ADDR_W'(1);
                            onehot_q <= dec(idx_q + ADDR_W'(1));
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_onehot = onehot_q;
    assign bus.out_idx    = idx_q;
    assign bus.err        = err_q;
    assign busy           = (state_q == StScan);
endmodule

// File: tb/tb_decoder_onehot_reg.sv
// Self-checking bench: two decoders (NUM_OUT=4/HOLD=0 and NUM_OUT=3/HOLD=1) share one stimulus
// stream and are compared every cycle against a transaction-level model.
module tb_decoder_onehot_reg;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_addr;
    logic       par;
    logic       scan_start;
    logic       out_ready;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per DUT.
    int num_out_c[2] = '{4, 3};
    int hold_c[2]    = '{0, 1};
    int m_valid[2], m_onehot[2], m_idx[2], m_err[2], m_scan[2];

    always #5 clk = ~clk;

    decoder_onehot_reg_if #(.ADDR_W(2), .NUM_OUT(4)) bus0 ();
    decoder_onehot_reg_if #(.ADDR_W(2), .NUM_OUT(3)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_addr   = in_addr;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_addr   = in_addr;
    assign bus1.out_ready = out_ready;
`ifdef DECODER_ONEHOT_PARITY_EN
    assign bus0.in_par = par;
    assign bus1.in_par = par;
`endif

    decoder_onehot_reg #(.ADDR_W(2), .NUM_OUT(4), .HOLD(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0.slave),
        .scan_start (scan_start),
        .busy       (busy0)
    );

    decoder_onehot_reg #(.ADDR_W(2), .NUM_OUT(3), .HOLD(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1.slave),
        .scan_start (scan_start),
        .busy       (busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_dut(input int d, input logic v, input logic [31:0] oh,
                             input logic [1:0] idx, input logic e, input logic rdy,
                             input logic bsy);
        bit exp_rdy;
        exp_rdy = (m_scan[d] == 0) && !scan_start && (m_valid[d] == 0 || out_ready);
        check($sformatf("d%0d_valid", d), 32'(v), 32'(m_valid[d]));
        check($sformatf("d%0d_onehot", d), oh, 32'(m_onehot[d]));
        check($sformatf("d%0d_idx", d), 32'(idx), 32'(m_idx[d]));
        check($sformatf("d%0d_err", d), 32'(e), 32'(m_err[d]));
        check($sformatf("d%0d_in_ready", d), 32'(rdy), 32'(exp_rdy));
        check($sformatf("d%0d_busy", d), 32'(bsy), 32'(m_scan[d]));
        check($sformatf("d%0d_onehot_bits", d), 32'($countones(oh) <= 1), 32'd1);
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step(input int d);
        bit accept, can_load, bad, par_ok;
        accept   = (m_valid[d] != 0) && out_ready;
        can_load = (m_valid[d] == 0) || out_ready;
`ifdef DECODER_ONEHOT_PARITY_EN
        par_ok = ($countones({par, in_addr}) % 2) == 0;
`else
        par_ok = 1'b1;
`endif
        if (rst) begin
            m_valid[d] = 0; m_onehot[d] = 0; m_idx[d] = 0; m_err[d] = 0; m_scan[d] = 0;
        end else if (m_scan[d] != 0) begin
            if (accept) begin
                if (m_idx[d] == num_out_c[d] - 1) begin
                    m_scan[d] = 0; m_valid[d] = 0; m_err[d] = 0;
                    if (hold_c[d] == 0) m_onehot[d] = 0;
                end else begin
                    m_idx[d]    = m_idx[d] + 1;
                    m_onehot[d] = 1 << m_idx[d];
                end
            end
        end else if (scan_start && can_load) begin
            m_scan[d] = 1; m_valid[d] = 1; m_idx[d] = 0; m_onehot[d] = 1; m_err[d] = 0;
        end else if (in_valid && can_load) begin
            bad         = (int'(in_addr) >= num_out_c[d]) || !par_ok;
            m_valid[d]  = 1;
            m_idx[d]    = int'(in_addr);
            m_err[d]    = bad ? 1 : 0;
            m_onehot[d] = bad ? 0 : (1 << in_addr);
        end else if (accept) begin
            m_valid[d] = 0; m_err[d] = 0;
            if (hold_c[d] == 0) m_onehot[d] = 0;
        end
    endtask

    task automatic cycle(input bit r, input bit iv, input logic [1:0] a, input bit p,
                         input bit ss, input bit ordy);
        @(negedge clk);
        rst = r; in_valid = iv; in_addr = a; par = p; scan_start = ss; out_ready = ordy;
        #1;
        check_dut(0, bus0.out_valid, 32'(bus0.out_onehot), bus0.out_idx, bus0.err,
                  bus0.in_ready, busy0);
        check_dut(1, bus1.out_valid, 32'(bus1.out_onehot), bus1.out_idx, bus1.err,
                  bus1.in_ready, busy1);
        model_step(0);
        model_step(1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; par = 1'b0; scan_start = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 0; m_onehot[d] = 0; m_idx[d] = 0; m_err[d] = 0; m_scan[d] = 0;
        end
        @(posedge clk);
        cycle(1, 0, 0, 0, 0, 1);
        // Back-to-back decode of every address (parity bit chosen even).
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 2'(i), ^2'(i), 0, 1);
        end
        cycle(0, 0, 0, 0, 0, 1);
        // Stall with a pending second request.
        cycle(0, 1, 2, 1, 0, 1);
        repeat (3) cycle(0, 1, 1, 1, 0, 0);
        cycle(0, 1, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // Out-of-range for the 3-output decoder, then a legal address.
        cycle(0, 1, 3, 0, 0, 1);
        cycle(0, 1, 1, 1, 0, 1);
        // HOLD behaviour after accept with nothing new.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // Scan and request together, then toggling backpressure with requests ignored.
        cycle(0, 1, 3, 0, 1, 1);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1, 3, 0, 0, i[0] == 1'b0);
        end
        // Reset mid-scan.
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // Parity sense: addr 01 with odd then even total parity.
        cycle(0, 1, 1, 0, 0, 1);
        cycle(0, 1, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 70);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decoder_onehot_reg.md
Name: decoder_onehot_reg

Overview:
- Registered, parametrised binary-to-one-hot decoder; successor to the 2-to-4 gate-level decoder.
- Generalised to ADDR_W address bits and NUM_OUT outputs.
- Adds a valid/ready handshake on both sides, out-of-range detection, and a self-driven scan mode.
- Scan mode walks every output once; used for select-line sweeps and bring-up.

Parameters:
- ADDR_W, 2, address width in bits; must be >= 1.
- NUM_OUT, 4, number of one-hot outputs; 2 <= NUM_OUT <= 2**ADDR_W.
- HOLD, 0, 1 = out_onehot keeps its last code after the handshake; 0 = out_onehot clears to zero after the handshake.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_addr is valid.
- in_addr  input  ADDR_W  binary select.
- in_ready  output  1  block accepts in_addr this cycle.
- scan_start  input  1  request a full sweep of outputs 0..NUM_OUT-1.
- out_valid  output  1  out_onehot and out_idx are valid.
- out_ready  input  1  downstream accepts the output.
- out_onehot  output  NUM_OUT  decoded one-hot word; bit k set means select k.
- out_idx  output  ADDR_W  index carried with out_onehot.
- err  output  1  qualified by out_valid; current output came from a rejected address.
- busy  output  1  scan in progress.

Behaviour:
- Reset: on rst=1 at a clk edge:
  - out_valid=0, out_onehot=0, out_idx=0, err=0, busy=0, state=IDLE.
  - rst overrides every other input.
  - Reset mid-scan aborts the scan immediately; no further outputs are produced.
- Output register: single entry. "Accept" means out_valid && out_ready.
- in_ready = (state==IDLE) && !scan_start && (!out_valid || out_ready). This is combinational.
- Decode transaction: when in_valid && in_ready at edge t, the result is visible at edge t+1 (latency 1):
  - out_valid=1 and out_idx=in_addr.
  - If in_addr < NUM_OUT: out_onehot = 1 << in_addr, err=0.
  - Else: out_onehot = 0, err=1.
- Back-to-back: an accept and a new capture in the same cycle loads the new value; throughput is 1 per clock. No bubble is inserted.
- Stall: while out_valid && !out_ready, out_onehot, out_idx and err are held stable.
- After accept with no new capture:
  - out_valid=0 and err=0.
  - out_onehot is held if HOLD=1, else cleared to 0.
  - out_idx is held.
- FSM states: IDLE and SCAN.
  - IDLE -> SCAN when scan_start=1 and (!out_valid || out_ready). On that edge busy=1 and the register loads idx 0 (out_onehot=1, out_valid=1).
  - SCAN: on each accept, load idx+1. When idx==NUM_OUT-1 is accepted, go to IDLE with busy=0. out_valid then follows the after-accept rule above.
  - SCAN ignores scan_start and in_valid; in_ready=0.
  - err is always 0 during a scan.
- Simultaneous scan_start and in_valid in IDLE: scan wins; in_valid is not accepted (in_ready=0).
- scan_start held high in IDLE with a stalled output: the scan begins on the first cycle the register can load.
- Index arithmetic: the counter is ADDR_W bits and never exceeds NUM_OUT-1; no wrap-around is visible.
- Invariant: out_onehot has at most one bit set at all times.

Optional Feature:
- Macro: DECODER_ONEHOT_PARITY_EN.
- Defined:
  - Adds input port in_par (1 bit), sampled with in_addr.
  - Required parity: even parity over {in_par, in_addr}.
  - On mismatch the capture gives out_onehot=0, err=1, out_idx=in_addr. This happens even if in_addr < NUM_OUT.
  - The scan path does not check parity.
- Not defined: the in_par port is absent; err reports out-of-range addresses only.

Test Plan:
- Reset and decode (ADDR_W=2, NUM_OUT=4, out_ready=1): after rst, send in_addr=0,1,2,3 on consecutive cycles -> out_onehot 0001, 0010, 0100, 1000 on the following cycles with out_valid=1 and err=0. Throughput is 1 per clock.
- Stall: in_addr=2 with out_ready=0 for 3 cycles -> out_onehot=0100 held and in_ready=0; a second in_valid is not taken until out_ready=1.
- Out-of-range (NUM_OUT=3): in_addr=3 -> out_onehot=000, err=1, out_idx=3. Then in_addr=1 -> 010, err=0.
- Scan with backpressure (NUM_OUT=4): pulse scan_start with out_ready toggling 1,0,1,... -> outputs 0001, 0010, 0100, 1000 in order, each held through the stall. busy=1 throughout and drops after 1000 is accepted. in_valid during the scan is ignored.
- HOLD and priority: with HOLD=1, decode in_addr=1 and accept -> out_valid=0, out_onehot=0010 retained; with HOLD=0 -> 0000. Assert scan_start and in_valid(in_addr=3) together -> scan runs and in_addr 3 is not consumed.
- Reset mid-scan, plus parity: rst at scan index 2 -> next cycle all outputs are 0 and busy=0. With DECODER_ONEHOT_PARITY_EN, in_addr=01 and in_par=0 -> err=1, out_onehot=0000; in_par=1 -> 0010, err=0.
